// File: rtl/urv_console_pkg.sv
// Shared definitions for the console UART: register offsets, STATUS bit
// positions, transmitter state encoding and the STATUS word packer.
package urv_console_pkg;

   // Register offsets within the 8-byte window
   localparam logic [2:0] TXDATA_OFS = 3'd0;
   localparam logic [2:0] STATUS_OFS = 3'd4;

   // STATUS bit positions
   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_DONE    = 4;
   localparam int ST_LVL_LSB = 8;
   localparam int ST_LVL_MSB = 12;

   // Transmitter state encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = S_IDLE,
      START = S_START,
      DATA  = S_DATA,
      STOP  = S_STOP
   } tx_state_t;

   // Assemble the STATUS word; unlisted bits read as zero
   function automatic logic [31:0] pack_status(
      input logic       full,
      input logic       empty,
      input logic       busy,
      input logic       ovf,
      input logic       done,
      input logic [4:0] lvl
   );
      logic [31:0] s;
      s = '0;
      s[ST_FULL]                = full;
      s[ST_EMPTY]               = empty;
      s[ST_BUSY]                = busy;
      s[ST_OVF]                 = ovf;
      s[ST_DONE]                = done;
      s[ST_LVL_MSB:ST_LVL_LSB]  = lvl;
      return s;
   endfunction

endpackage

// File: rtl/urv_sync_fifo.sv
// Single-clock FIFO with combinational head read. A push while full is only
// accepted when a pop happens in the same cycle; otherwise it is ignored and
// the parent decides whether that counts as an overflow.
module urv_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     wclk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level_reg == LW'(DEPTH));
   assign empty   = (level_reg == '0);
   assign level   = level_reg;
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rd_data = mem[rd_ptr_reg];

   // Storage array, written only on an accepted push (no reset on the data)
   always_ff @(posedge wclk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge wclk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/urv_console_uart.sv
// Memory-mapped console transmitter: TXDATA stores are staged one cycle,
// queued in a FIFO and sent as 8N1 frames on txd_o. STATUS is readable and
// done_o latches once a 0xFF byte has completed its stop bit.
module urv_console_uart
   import urv_console_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        wclk,
   input  logic        rst,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_store_i,
   input  logic        dm_load_i,
   output logic        hit_o,
   output logic [31:0] dm_data_l_o,
   output logic        txd_o,
   output logic        done_o
);
   localparam int            LW        = $clog2(FIFO_DEPTH) + 1;
   localparam int            BW        = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   // Bus decode
   logic        sel_txdata;
   logic        sel_status;
   logic        store_txdata;
   logic        clr_ovf;
   logic [31:0] status_word;
   logic        unused_bits;

   // Staged push, FIFO and overflow tracking
   logic          stage_valid_reg;
   logic [7:0]    stage_byte_reg;
   logic          overflow_reg;
   logic [31:0]   rdata_reg;
   logic [7:0]    fifo_rd_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic [LW-1:0] fifo_level;
   logic          pop_req;

   // Transmitter
   tx_state_t     state_reg;
   logic [BW-1:0] baud_reg;
   logic [2:0]    bit_reg;
   logic [7:0]    shift_reg;
   logic [7:0]    byte_reg;
   logic          txd_reg;
   logic          done_reg;

   assign hit_o        = (dm_addr_i[31:3] == BASE_ADDR[31:3]);
   assign sel_txdata   = (dm_addr_i[2] == TXDATA_OFS[2]);
   assign sel_status   = (dm_addr_i[2] == STATUS_OFS[2]);
   assign store_txdata = dm_store_i && hit_o && sel_txdata && dm_data_select_i[0];
   assign clr_ovf      = dm_store_i && hit_o && sel_status && dm_data_select_i[0]
                         && dm_data_s_i[ST_OVF];
   assign unused_bits  = ^{dm_addr_i[1:0], dm_data_s_i[31:8], dm_data_select_i[3:1]};

   assign status_word = pack_status(fifo_full, fifo_empty, state_reg != IDLE,
                                    overflow_reg, done_reg, 5'(fifo_level));

   assign txd_o       = txd_reg;
   assign done_o      = done_reg;
   assign dm_data_l_o = rdata_reg;

   // The transmitter takes the head byte when idle, or straight from the end
   // of a stop bit so queued frames follow each other without a gap
   always_comb begin
      pop_req = 1'b0;
      if (!fifo_empty) begin
         if (state_reg == IDLE) begin
            pop_req = 1'b1;
         end else if (state_reg == STOP && baud_reg == BAUD_LAST) begin
            pop_req = 1'b1;
         end
      end
   end

   urv_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .wclk    (wclk),
      .rst     (rst),
      .push    (stage_valid_reg),
      .wr_data (stage_byte_reg),
      .pop     (pop_req),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Stage TXDATA stores, track overflow and register load data
   always_ff @(posedge wclk or negedge rst) begin
      if (!rst) begin
         stage_valid_reg <= 1'b0;
         stage_byte_reg  <= '0;
         overflow_reg    <= 1'b0;
         rdata_reg       <= '0;
      end else begin
         stage_valid_reg <= store_txdata;
         if (store_txdata) begin
            stage_byte_reg <= dm_data_s_i[7:0];
         end
         // A dropped byte wins over a same-cycle clear so it is never missed
         if (stage_valid_reg && fifo_full && !pop_req) begin
            overflow_reg <= 1'b1;
         end else if (clr_ovf) begin
            overflow_reg <= 1'b0;
         end
         if (dm_load_i && hit_o) begin
            rdata_reg <= sel_status ? status_word : 32'h0;
         end
      end
   end

   // 8N1 serialiser: start bit, eight data bits LSB first, stop bit
   always_ff @(posedge wclk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         byte_reg  <= '0;
         txd_reg   <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!fifo_empty) begin
                  shift_reg <= fifo_rd_data;
                  byte_reg  <= fifo_rd_data;
                  baud_reg  <= '0;
                  txd_reg   <= 1'b0;
                  state_reg <= START;
               end
            end
            START: begin
               if (baud_reg == BAUD_LAST) begin
                  baud_reg  <= '0;
                  bit_reg   <= '0;
                  txd_reg   <= shift_reg[0];
                  state_reg <= DATA;
               end else begin
                  baud_reg <= baud_reg + BW'(1);
               end
            end
            DATA: begin
               if (baud_reg == BAUD_LAST) begin
                  baud_reg <= '0;
                  if (bit_reg == 3'd7) begin
                     txd_reg   <= 1'b1;
                     state_reg <= STOP;
                  end else begin
                     bit_reg   <= bit_reg + 3'd1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     txd_reg   <= shift_reg[1];
                  end
               end else begin
                  baud_reg <= baud_reg + BW'(1);
               end
            end
            STOP: begin
               if (baud_reg == BAUD_LAST) begin
                  baud_reg <= '0;
                  if (byte_reg == 8'hFF) begin
                     done_reg <= 1'b1;
                  end
                  if (!fifo_empty) begin
                     shift_reg <= fifo_rd_data;
                     byte_reg  <= fifo_rd_data;
                     txd_reg   <= 1'b0;
                     state_reg <= START;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else begin
                  baud_reg <= baud_reg + BW'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               txd_reg   <= 1'b1;
            end
         endcase
      end
   end

endmodule
